// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch queue.
package fetch_pkg;

    localparam int unsigned DEPTH_DEFAULT   = 4;
    localparam int unsigned PC_INCR_DEFAULT = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        DRAIN = 2'd2
    } fetch_state_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// First-word fall-through FIFO of {pc, instr} entries with a synchronous flush.
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int unsigned DEPTH = DEPTH_DEFAULT
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         flush,
    input  logic         push,
    input  fetch_entry_t push_data,
    input  logic         pop,
    output fetch_entry_t head,
    output logic         valid,
    output logic         full
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = PTR_W + 1;

    fetch_entry_t     mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [CNT_W-1:0] count;
    logic             do_push;
    logic             do_pop;

    // Flush dominates both ends of the queue.
    assign do_push = push & ~flush;
    assign do_pop  = pop & valid & ~flush;

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    assign head  = mem[rd_ptr];
    assign valid = (count != '0);
    assign full  = (count == CNT_W'(DEPTH));

    // Launch gating guarantees a push never meets a full queue.
    always_ff @(posedge clk) begin
        if (!reset) begin
            assert (!(push && full)) else $error("fetch_fifo: push while full");
        end
    end

endmodule

// File: rtl/fetch_queue.sv
// Fetch unit: drives the PC, fetches over a req/ack memory port and buffers results for decode.
module fetch_queue
    import fetch_pkg::*;
#(
    parameter int unsigned DEPTH   = DEPTH_DEFAULT,
    parameter int unsigned PC_INCR = PC_INCR_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] pc_current,
    output logic [31:0] pc_next,
    output logic        pc_enable,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    output logic        dec_valid,
    output logic [31:0] dec_instr,
    output logic [31:0] dec_pc,
    input  logic        dec_ready
);

    fetch_state_t state;
    fetch_state_t state_next;
    logic         launch;
    logic         push;
    logic         pop;
    logic         full;
    fetch_entry_t push_data;
    fetch_entry_t head;

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            imem_addr <= '0;
        end else begin
            state <= state_next;
            if (launch) begin
                imem_addr <= pc_current;
            end
        end
    end

    // Next state, fetch push and PC update; a branch overrides the PC mux in any state.
    always_comb begin
        state_next = state;
        launch     = 1'b0;
        push       = 1'b0;
        pc_enable  = 1'b0;
        pc_next    = pc_current + 32'(PC_INCR);
        case (state)
            IDLE: begin
                if (!branch_taken && !full) begin
                    launch     = 1'b1;
                    state_next = REQ;
                end
            end
            REQ: begin
                if (imem_ack) begin
                    state_next = IDLE;
                    if (!branch_taken) begin
                        push      = 1'b1;
                        pc_enable = 1'b1;
                    end
                end else if (branch_taken) begin
                    state_next = DRAIN;
                end
            end
            DRAIN: begin
                if (imem_ack) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
        if (branch_taken) begin
            pc_enable = 1'b1;
            pc_next   = branch_target;
        end
    end

    assign imem_req  = (state == REQ) || (state == DRAIN);
    assign pop       = dec_valid & dec_ready & ~branch_taken;
    assign push_data = '{pc: imem_addr, instr: imem_rdata};

    fetch_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .flush     (branch_taken),
        .push      (push),
        .push_data (push_data),
        .pop       (pop),
        .head      (head),
        .valid     (dec_valid),
        .full      (full)
    );

    assign dec_instr = head.instr;
    assign dec_pc    = head.pc;

endmodule
